sdfa_layer_block: RTL and testbench

Fixed-configuration spiking-neuron layer block for the SDFA array. The block holds a 256-row × 256-weight (14-bit) synaptic SRAM. In the front phase it accumulates weighted input spikes into output-neuron membrane potentials. In the back phase it thresholds those potentials and streams one output spike per neuron. The two phases overlap across images, with a master sequencing them via START/EN and REQUEST.

---
 rtl/sdfa_layer_block.sv | 220 ++++++++++++++++++++++
 tb/tb_sdfa_layer_block.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdfa_layer_block.sv
// SDFA spiking-neuron layer: weighted spike accumulation (front) and thresholded serial spike stream (back).
// Define SDFA_SATURATE_EN to saturate membrane potentials instead of wrapping them.

module sdfa_sram_256 (
   input  logic          CLK,
   input  logic [7:0]    ADDR,
   input  logic [3583:0] DIN,
   input  logic [31:0]   WE,
   input  logic          EN_M,
   output logic [3583:0] DOUT
);
   logic [3583:0] mem [256];

   always_ff @(posedge CLK) begin
      if (!EN_M) begin
         for (int s = 0; s < 32; s++)
            if (!WE[s]) mem[ADDR][s*112 +: 112] <= DIN[s*112 +: 112];
         DOUT <= mem[ADDR];
      end
   end
endmodule

module sdfa_layer_block #(
   parameter logic [2:0] BLOCK_ID  = 3'd0,
   parameter int         THRESHOLD = 0
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        START,
   input  logic        EN,
   input  logic        REQUEST,
   input  logic [7:0]  DATA_IN,
   input  logic [22:0] BLOCK_INFO,
   output logic        MEM_SETUP_DONE,
   output logic        FRONT_DONE,
   output logic        OUT_SPIKE_VALID,
   output logic        BACK_DONE,
   output logic        OUT_SPIKE
);
   localparam int DATA_W  = 8;
   localparam int COEF_W  = 14;
   localparam int ACC_W   = 22;
   localparam int SUM_W   = 18;
   localparam int NEURONS = 128;
   localparam int ROW_W   = 256;
   localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESHOLD);

   typedef enum logic [1:0] {L8, L4, L2} lane_e;
   typedef enum logic {BK_IDLE, BK_STREAM} back_e;

   function automatic lane_e lane_mode(input logic [2:0] keep);
      case (keep)
         3'b011:  return L4;
         3'b001:  return L2;
         default: return L8;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] lane_mask(input lane_e m);
      case (m)
         L4:      return 8'h0F;
         L2:      return 8'h03;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [SUM_W-1:0] d);
`ifdef SDFA_SATURATE_EN
      logic signed [ACC_W:0] s;
      s = (ACC_W+1)'(a) + (ACC_W+1)'(d);
      if (s > (ACC_W+1)'(2**(ACC_W-1) - 1)) return ACC_W'(2**(ACC_W-1) - 1);
      if (s < -(ACC_W+1)'(2**(ACC_W-1)))    return ACC_W'(-(2**(ACC_W-1)));
      return s[ACC_W-1:0];
`else
      return a + ACC_W'(d);
`endif
   endfunction

   logic [2:0]  keep_q;
   logic [7:0]  nmr_q, nout_q;
   lane_e       mode;

   logic        front_active_q, beat, last_beat, front_busy;
   logic [7:0]  row_q;
   logic        vld_p0, vld_p1, last_p0, last_p1;
   logic [7:0]  addr_p0;
   logic [DATA_W-1:0] data_p0, data_p1;
   logic [3583:0] dout;
   logic signed [COEF_W-1:0] w     [ROW_W];
   logic signed [SUM_W-1:0]  delta [NEURONS];
   logic signed [ACC_W-1:0]  pot_q [NEURONS];

   back_e        state_q, state_d;
   logic         accept;
   logic [7:0]   idx_q;
   logic [NEURONS-1:0] spk_q;

   assign mode       = lane_mode(keep_q);
   assign beat       = EN && (START || front_active_q);
   assign last_beat  = beat && (START ? (nmr_q == 8'd0) : (row_q == nmr_q));
   assign front_busy = front_active_q | vld_p0 | vld_p1;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         keep_q         <= '0;
         nmr_q          <= '0;
         nout_q         <= '0;
         MEM_SETUP_DONE <= 1'b0;
      end else if (BLOCK_INFO[22] && BLOCK_INFO[21:19] == BLOCK_ID) begin
         keep_q         <= BLOCK_INFO[18:16];
         nmr_q          <= BLOCK_INFO[15:8];
         nout_q         <= BLOCK_INFO[7:0];
         MEM_SETUP_DONE <= 1'b1;
      end
   end

   // Stage p0: beat accepted, row address issued to the SRAM
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         front_active_q <= 1'b0;
         row_q          <= '0;
         vld_p0         <= 1'b0;
         last_p0        <= 1'b0;
         vld_p1         <= 1'b0;
         last_p1        <= 1'b0;
         FRONT_DONE     <= 1'b0;
      end else begin
         vld_p0  <= beat;
         last_p0 <= last_beat;
         vld_p1  <= vld_p0;
         last_p1 <= last_p0;
         if (vld_p1 && last_p1) FRONT_DONE <= 1'b1;
         if (EN && START) begin
            front_active_q <= !last_beat;
            row_q          <= 8'd1;
            FRONT_DONE     <= 1'b0;
         end else if (beat) begin
            front_active_q <= !last_beat;
            row_q          <= row_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      addr_p0 <= (EN && START) ? 8'd0 : row_q;
      data_p0 <= DATA_IN & lane_mask(mode);
      data_p1 <= data_p0;
   end

   sdfa_sram_256 u_sdfa_sram_256 (
      .CLK  (CLK),
      .ADDR (addr_p0),
      .DIN  ({3584{1'b0}}),
      .WE   ({32{1'b1}}),
      .EN_M (1'b0),
      .DOUT (dout)
   );

   // Stage p1: row weights available, per-neuron beat sums formed
   always_comb begin
      for (int j = 0; j < ROW_W; j++) w[j] = dout[j*COEF_W +: COEF_W];
      for (int k = 0; k < NEURONS; k++) delta[k] = '0;
      for (int j = 0; j < ROW_W; j++) begin
         case (mode)
            L4: if (data_p1[3'(j & 3)]) delta[7'(j >> 2)] = delta[7'(j >> 2)] + SUM_W'(w[8'(j)]);
            L2: if (data_p1[3'(j & 1)]) delta[7'(j >> 1)] = delta[7'(j >> 1)] + SUM_W'(w[8'(j)]);
            default: if (data_p1[3'(j)]) delta[7'(j >> 3)] = delta[7'(j >> 3)] + SUM_W'(w[8'(j)]);
         endcase
      end
   end

   // Stage p2: potentials updated; a back-phase snapshot clears them instead
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int k = 0; k < NEURONS; k++) pot_q[k] <= '0;
         spk_q <= '0;
      end else if (accept) begin
         for (int k = 0; k < NEURONS; k++) begin
            spk_q[k] <= pot_q[k] > THR;
            pot_q[k] <= '0;
         end
      end else if (vld_p1) begin
         for (int k = 0; k < NEURONS; k++)
            if (8'(k) <= nout_q) pot_q[k] <= acc_add(pot_q[k], delta[k]);
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         BK_IDLE:   if (REQUEST && !front_busy) begin
                       accept  = 1'b1;
                       state_d = BK_STREAM;
                    end
         BK_STREAM: if (idx_q == nout_q) state_d = BK_IDLE;
         default:   state_d = BK_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q         <= BK_IDLE;
         idx_q           <= '0;
         OUT_SPIKE_VALID <= 1'b0;
         OUT_SPIKE       <= 1'b0;
         BACK_DONE       <= 1'b0;
      end else begin
         state_q         <= state_d;
         OUT_SPIKE_VALID <= (state_q == BK_STREAM);
         OUT_SPIKE       <= (state_q == BK_STREAM) && !idx_q[7] && spk_q[idx_q[6:0]];
         if (accept) idx_q <= '0;
         else if (state_q == BK_STREAM) idx_q <= idx_q + 8'd1;
         // Done one cycle after the final spike leaves
         if (accept) BACK_DONE <= 1'b0;
         else if (OUT_SPIKE_VALID && state_q == BK_IDLE) BACK_DONE <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sdfa_layer_block.sv
// Scoreboard bench for sdfa_layer_block: a plain-arithmetic neuron model predicts each spike stream.
module tb_sdfa_layer_block;
   localparam int THR = 0;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        START = 1'b0, EN = 1'b0, REQUEST = 1'b0;
   logic [7:0]  DATA_IN = '0;
   logic [22:0] BLOCK_INFO = '0;
   logic        MEM_SETUP_DONE, FRONT_DONE, OUT_SPIKE_VALID, BACK_DONE, OUT_SPIKE;

   sdfa_layer_block #(.BLOCK_ID(3'd0), .THRESHOLD(THR)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .EN(EN), .REQUEST(REQUEST),
      .DATA_IN(DATA_IN), .BLOCK_INFO(BLOCK_INFO), .MEM_SETUP_DONE(MEM_SETUP_DONE),
      .FRONT_DONE(FRONT_DONE), .OUT_SPIKE_VALID(OUT_SPIKE_VALID), .BACK_DONE(BACK_DONE),
      .OUT_SPIKE(OUT_SPIKE)
   );

   always #5 CLK = ~CLK;

   int     vectors = 0, miscompares = 0;
   bit     exp_q[$];
   int     w [256][256];
   longint pot [128];
   int     m_keep = 0, m_nmr = 0, m_nout = 0;
   bit     m_setup = 0;

   function automatic int lanes_of(input int keep);
      if (keep == 3) return 4;
      if (keep == 1) return 2;
      return 8;
   endfunction

   function automatic longint fold(input longint v);
`ifdef SDFA_SATURATE_EN
      if (v > 2097151) return 2097151;
      if (v < -2097152) return -2097152;
      return v;
`else
      longint m;
      m = v & 64'h3FFFFF;
      if (m >= 64'sd2097152) m = m - 64'sd4194304;
      return m;
`endif
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge CLK); #1;
   endtask

   // Monitor: every valid cycle pops one expected spike; idle cycles must show OUT_SPIKE=0
   always @(negedge CLK) begin
      if (RESET_N) begin
         if (OUT_SPIKE_VALID) begin
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_spike: valid spike %0d with nothing expected at %0t", OUT_SPIKE, $time);
            end else begin
               check("spike", OUT_SPIKE, exp_q.pop_front());
            end
         end else begin
            check("idle_spike", OUT_SPIKE, 0);
         end
      end
   end

   task automatic load_weights(input int kind);
      logic [3583:0] row;
      for (int r = 0; r < 256; r++) begin
         for (int j = 0; j < 256; j++) begin
            case (kind)
               0: w[r][j] = 1;
               1: w[r][j] = -1;
               2: w[r][j] = (j % 8 == 0) ? 5 : -5;
               default: w[r][j] = int'($urandom_range(0, 16383)) - 8192;
            endcase
            row[14*j +: 14] = 14'(w[r][j]);
         end
         dut.u_sdfa_sram_256.mem[r] = row;
      end
   endtask

   task automatic config_blk(input int blk, input int keep, input int nmr, input int nout);
      BLOCK_INFO = {1'b1, 3'(blk), 3'(keep), 8'(nmr), 8'(nout)};
      tick;
      BLOCK_INFO = '0;
      if (blk == 0) begin
         m_keep = keep; m_nmr = nmr; m_nout = nout; m_setup = 1;
      end
      check("mem_setup_done", MEM_SETUP_DONE, m_setup);
   endtask

   task automatic model_beat(input logic [7:0] d, input int r);
      int b_lanes;
      longint s;
      b_lanes = lanes_of(m_keep);
      for (int k = 0; k <= m_nout && k < 128; k++) begin
         s = 0;
         for (int b = 0; b < b_lanes; b++)
            if (k * b_lanes + b < 256 && d[b]) s += w[r][k * b_lanes + b];
         pot[k] = fold(pot[k] + s);
      end
   endtask

   task automatic send_image(input int gap_pct, input bit rnd, input logic [7:0] dval, input int extra);
      logic [7:0] d;
      for (int r = 0; r <= m_nmr; r++) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            EN = 0; START = 0;
            repeat ($urandom_range(1, 3)) tick;
         end
         d = rnd ? 8'($urandom) : dval;
         EN = 1; START = (r == 0); DATA_IN = d;
         model_beat(d, r);
         tick;
      end
      EN = 0; START = 0;
      tick;
      check("front_done_early", FRONT_DONE, 0);
      tick;
      check("front_done", FRONT_DONE, 1);
      for (int i = 0; i < extra; i++) begin
         EN = 1; DATA_IN = 8'($urandom);
         tick;
      end
      EN = 0;
   endtask

   task automatic request(input bit extra_req);
      int n, cnt;
      bit done;
      n = m_nout;
      for (int k = 0; k <= n; k++) exp_q.push_back((k < 128) ? (pot[k] > THR) : 1'b0);
      for (int k = 0; k < 128; k++) pot[k] = 0;
      REQUEST = 1;
      tick;
      REQUEST = 0;
      check("back_done_cleared", BACK_DONE, 0);
      cnt = 0; done = 0;
      while (!done && cnt < n + 20) begin
         tick;
         cnt++;
         if (cnt == 1) check("first_valid", OUT_SPIKE_VALID, 1);
         REQUEST = extra_req && (cnt == 1);
         if (BACK_DONE) done = 1;
      end
      REQUEST = 0;
      check("back_done_latency", cnt, n + 2);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      int keeps[4] = '{7, 3, 1, 5};
      for (int k = 0; k < 128; k++) pot[k] = 0;
      repeat (3) tick;
      check("rst_mem_setup", MEM_SETUP_DONE, 0);
      check("rst_front_done", FRONT_DONE, 0);
      check("rst_valid", OUT_SPIKE_VALID, 0);
      check("rst_back_done", BACK_DONE, 0);
      check("rst_spike", OUT_SPIKE, 0);
      RESET_N = 1;
      tick;

      // Wrong block number must not latch, then the canonical config and first request
      config_blk(3, 7, 255, 31);
      config_blk(0, 7, 255, 31);
      request(0);
      check("back_done_hold", BACK_DONE, 1);

      load_weights(0);
      send_image(0, 0, 8'hFF, 0);
      START = 1; EN = 0; tick; START = 0; tick;
      check("start_without_en", FRONT_DONE, 1);
      request(1);

      load_weights(1);
      config_blk(0, 3, 255, 63);
      send_image(10, 1, 8'h00, 0);
      request(1);
      config_blk(0, 1, 255, 127);
      send_image(10, 1, 8'h00, 0);
      request(1);

      load_weights(2);
      config_blk(0, 7, 255, 31);
      send_image(0, 0, 8'h01, 0);
      request(0);
      send_image(0, 0, 8'h02, 0);
      request(0);

      // Three overlapping images on random weights
      load_weights(3);
      config_blk(0, keeps[$urandom_range(0, 3)], $urandom_range(40, 90), $urandom_range(8, 127));
      send_image(20, 1, 8'h00, 2);
      for (int img = 0; img < 3; img++) begin
         fork
            request(1);
            begin
               if (img < 2) begin
                  c = 0;
                  while (!OUT_SPIKE_VALID && c < 50) begin tick; c++; end
                  check("valid_rise", OUT_SPIKE_VALID, 1);
                  tick; tick;
                  send_image(20, 1, 8'h00, 2);
               end
            end
         join
         c = 0;
         while (!(BACK_DONE && FRONT_DONE) && c < 400) begin tick; c++; end
         check("both_done", BACK_DONE && FRONT_DONE, 1);
      end

      // Reset in the middle of a front phase
      load_weights(0);
      config_blk(0, 7, 255, 31);
      for (int r = 0; r < 100; r++) begin
         EN = 1; START = (r == 0); DATA_IN = 8'hFF;
         model_beat(8'hFF, r);
         tick;
      end
      EN = 0; START = 0;
      RESET_N = 0;
      #1;
      for (int k = 0; k < 128; k++) pot[k] = 0;
      m_setup = 0;
      check("midrst_mem_setup", MEM_SETUP_DONE, 0);
      check("midrst_front_done", FRONT_DONE, 0);
      check("midrst_valid", OUT_SPIKE_VALID, 0);
      check("midrst_back_done", BACK_DONE, 0);
      check("midrst_spike", OUT_SPIKE, 0);
      tick;
      RESET_N = 1;
      tick;
      check("post_rst_mem_setup", MEM_SETUP_DONE, 0);
      config_blk(0, 7, 255, 31);
      request(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
